// File: rtl/triangle_scan_ctrl_if.sv
// Query-point and scan-result handshake bundle for triangle_scan_ctrl.
// Master drives the point and accepts the result; slave is the scanner.
interface triangle_scan_ctrl_if #(
  parameter int TRI_AW = 2
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [10:0]      in_x;
  logic signed [10:0]      in_y;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_hit;
  logic [TRI_AW-1:0]       out_idx;

  modport master (
    output in_valid,
    output in_x,
    output in_y,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_hit,
    input  out_idx
  );

  modport slave (
    input  in_valid,
    input  in_x,
    input  in_y,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_hit,
    output out_idx
  );
endinterface

// File: rtl/triangle_scan_ctrl.sv
// Point-in-triangle scanner over a slot bank, sharing one edge evaluator.
// Reports the lowest-index hit or a miss on a valid/ready result port.
module triangle_scan_ctrl #(
  parameter int TRI_AW = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               cfg_we,
  input  logic [TRI_AW-1:0]  cfg_addr,
  input  logic [1:0]         cfg_vtx,
  input  logic signed [10:0] cfg_x,
  input  logic signed [10:0] cfg_y,
  triangle_scan_ctrl_if.slave bus,
  output logic               busy
);

  localparam int NTRI = 2 ** TRI_AW;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic signed [10:0] vx_q [NTRI][3];
  logic signed [10:0] vy_q [NTRI][3];
  logic [NTRI-1:0]    tri_valid_q;

  logic signed [10:0] px_q;
  logic signed [10:0] py_q;
  logic [TRI_AW-1:0]  slot_q;
  logic [1:0]         eidx_q;
  logic [1:0]         sgn_q;
  logic               hit_q;
  logic [TRI_AW-1:0]  idx_q;

  logic               cfg_take;
  logic               accept;
  logic               step;
  logic               adv;
  logic               done_hit;
  logic               done_miss;

  // Edge datapath: a = v[eidx], b = v[eidx+1 mod 3]
  logic [1:0]         nidx;
  logic signed [10:0] ax;
  logic signed [10:0] ay;
  logic signed [10:0] bx;
  logic signed [10:0] by;
  logic signed [11:0] dpx;
  logic signed [11:0] dpy;
  logic signed [11:0] dax;
  logic signed [11:0] day;
  logic signed [23:0] p0;
  logic signed [23:0] p1;
  logic signed [24:0] s;
  logic               e_neg;
  logic               slot_ok;
  logic               last;
  logic               tri_hit;

  assign nidx = (eidx_q == 2'd2) ? 2'd0 : eidx_q + 2'd1;
  assign ax   = vx_q[slot_q][eidx_q];
  assign ay   = vy_q[slot_q][eidx_q];
  assign bx   = vx_q[slot_q][nidx];
  assign by   = vy_q[slot_q][nidx];

  assign dpx  = {px_q[10], px_q} - {bx[10], bx};
  assign dpy  = {py_q[10], py_q} - {by[10], by};
  assign dax  = {ax[10], ax} - {bx[10], bx};
  assign day  = {ay[10], ay} - {by[10], by};
  assign p0   = dpx * day;
  assign p1   = dax * dpy;
  assign s    = {p0[23], p0} - {p1[23], p1};
  assign e_neg = (s < 25'sd0);

  assign slot_ok = tri_valid_q[slot_q];
  assign last    = (slot_q == TRI_AW'(NTRI - 1));
  assign tri_hit = (sgn_q[0] == sgn_q[1]) && (sgn_q[1] == e_neg);

  assign cfg_take = (state_q == IDLE) && cfg_we && (cfg_vtx != 2'd3);
  assign accept   = (state_q == IDLE) && bus.in_valid;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    step      = 1'b0;
    adv       = 1'b0;
    done_hit  = 1'b0;
    done_miss = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) state_d = EVAL;
      end
      EVAL: begin
        // Invalid slots cost one cycle; valid ones decide on E2.
        if (!slot_ok || eidx_q == 2'd2) begin
          if (slot_ok && tri_hit) begin
            state_d  = DONE;
            done_hit = 1'b1;
          end else if (last) begin
            state_d   = DONE;
            done_miss = 1'b1;
          end else begin
            adv = 1'b1;
          end
        end else begin
          step = 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NTRI; i++) begin
        for (int j = 0; j < 3; j++) begin
          vx_q[i][j] <= '0;
          vy_q[i][j] <= '0;
        end
      end
      tri_valid_q <= '0;
      px_q        <= '0;
      py_q        <= '0;
      slot_q      <= '0;
      eidx_q      <= '0;
      sgn_q       <= '0;
      hit_q       <= 1'b0;
      idx_q       <= '0;
    end else begin
      if (cfg_take) begin
        vx_q[cfg_addr][cfg_vtx] <= cfg_x;
        vy_q[cfg_addr][cfg_vtx] <= cfg_y;
        if (cfg_vtx == 2'd0) tri_valid_q[cfg_addr] <= 1'b0;
        if (cfg_vtx == 2'd2) tri_valid_q[cfg_addr] <= 1'b1;
      end
      if (accept) begin
        px_q   <= bus.in_x;
        py_q   <= bus.in_y;
        slot_q <= '0;
        eidx_q <= '0;
      end
      if (step) begin
        sgn_q[eidx_q[0]] <= e_neg;
        eidx_q           <= eidx_q + 2'd1;
      end
      if (adv) begin
        slot_q <= slot_q + 1'b1;
        eidx_q <= '0;
      end
      if (done_hit) begin
        hit_q <= 1'b1;
        idx_q <= slot_q;
      end
      if (done_miss) begin
        hit_q <= 1'b0;
        idx_q <= '0;
      end
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_hit   = hit_q;
  assign bus.out_idx   = idx_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_triangle_scan_ctrl.sv
// Directed bench for triangle_scan_ctrl: hits, misses, latency,
// config gating, result hold and asynchronous reset.
module tb_triangle_scan_ctrl;

  localparam int TRI_AW = 2;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              cfg_we = 1'b0;
  logic [TRI_AW-1:0] cfg_addr = '0;
  logic [1:0]        cfg_vtx = '0;
  logic signed [10:0] cfg_x = '0;
  logic signed [10:0] cfg_y = '0;
  logic              busy;

  int n_tests = 0;
  int n_fail  = 0;

  triangle_scan_ctrl_if #(.TRI_AW(TRI_AW)) bus_if ();

  triangle_scan_ctrl #(.TRI_AW(TRI_AW)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_vtx  (cfg_vtx),
    .cfg_x    (cfg_x),
    .cfg_y    (cfg_y),
    .bus      (bus_if),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wr(input int slot, input int v, input int x, input int y);
    @(negedge clock);
    cfg_we   = 1'b1;
    cfg_addr = TRI_AW'(slot);
    cfg_vtx  = 2'(v);
    cfg_x    = 11'(x);
    cfg_y    = 11'(y);
    @(posedge clock);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic query(input string tag, input int x, input int y,
                       input int hit, input int idx, input int c,
                       input bit pre_rdy, input bit mid_we,
                       input bit co_we, input int hold);
    int n;
    @(negedge clock);
    chk({tag, "_in_rdy"}, int'(bus_if.in_ready), 1);
    bus_if.in_valid = 1'b1;
    bus_if.in_x     = 11'(x);
    bus_if.in_y     = 11'(y);
    if (pre_rdy) bus_if.out_ready = 1'b1;
    if (co_we) begin
      cfg_we   = 1'b1;
      cfg_addr = '0;
      cfg_vtx  = 2'd2;
      cfg_x    = 11'sd12;
      cfg_y    = 11'sd11;
    end
    @(posedge clock);
    #1;
    bus_if.in_valid = 1'b0;
    cfg_we = 1'b0;
    chk({tag, "_rdy_low"}, int'(bus_if.in_ready), 0);
    chk({tag, "_busy"}, int'(busy), 1);
    if (mid_we) begin
      cfg_we   = 1'b1;
      cfg_addr = '0;
      cfg_vtx  = 2'd0;
      cfg_x    = 11'sd100;
      cfg_y    = 11'sd100;
    end
    n = 0;
    do begin
      @(posedge clock);
      #1;
      cfg_we = 1'b0;
      n++;
    end while (!bus_if.out_valid && n < 64);
    chk({tag, "_lat"}, n, c);
    chk({tag, "_hit"}, int'(bus_if.out_hit), hit);
    chk({tag, "_idx"}, int'(bus_if.out_idx), idx);
    for (int k = 0; k < hold; k++) begin
      @(posedge clock);
      #1;
      chk({tag, "_hold_v"}, int'(bus_if.out_valid), 1);
      chk({tag, "_hold_h"}, int'(bus_if.out_hit), hit);
      chk({tag, "_hold_i"}, int'(bus_if.out_idx), idx);
      chk({tag, "_hold_r"}, int'(bus_if.in_ready), 0);
    end
    @(negedge clock);
    bus_if.out_ready = 1'b1;
    @(posedge clock);
    #1;
    bus_if.out_ready = 1'b0;
    chk({tag, "_ov_low"}, int'(bus_if.out_valid), 0);
    chk({tag, "_rdy_back"}, int'(bus_if.in_ready), 1);
  endtask

  initial begin
    bus_if.in_valid  = 1'b0;
    bus_if.in_x      = '0;
    bus_if.in_y      = '0;
    bus_if.out_ready = 1'b0;
    #1;
    chk("rst_in_rdy", int'(bus_if.in_ready), 1);
    chk("rst_ov", int'(bus_if.out_valid), 0);
    chk("rst_hit", int'(bus_if.out_hit), 0);
    chk("rst_idx", int'(bus_if.out_idx), 0);
    chk("rst_busy", int'(busy), 0);
    #13;
    reset_n = 1'b1;

    wr(0, 0, 4, 9);
    wr(0, 1, 9, 5);
    wr(0, 2, 12, 11);
    query("t1", 9, 9, 1, 0, 3, 0, 0, 0, 0);

    wr(1, 0, 6, 1);
    wr(1, 1, 9, 3);
    wr(1, 2, -4, 15);
    query("t2", 5, 3, 1, 1, 6, 0, 0, 0, 0);

    query("t3_vtx", 9, 5, 1, 0, 3, 1, 0, 0, 0);

    query("t4_miss", 3, 1, 0, 0, 8, 0, 0, 0, 5);

    query("t5_we", 9, 9, 1, 0, 3, 0, 1, 0, 0);
    query("t5_chk", 9, 9, 1, 0, 3, 0, 0, 0, 0);

    wr(0, 0, 4, 9);
    query("t6_skip", 5, 3, 1, 1, 4, 0, 0, 0, 0);

    query("t7_co", 9, 9, 1, 0, 3, 0, 0, 1, 0);

    @(negedge clock);
    bus_if.in_valid = 1'b1;
    bus_if.in_x     = 11'sd3;
    bus_if.in_y     = 11'sd1;
    @(posedge clock);
    #1;
    bus_if.in_valid = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #2;
    chk("t8_busy_pre", int'(busy), 1);
    reset_n = 1'b0;
    #1;
    chk("t8_ov", int'(bus_if.out_valid), 0);
    chk("t8_rdy", int'(bus_if.in_ready), 1);
    chk("t8_busy", int'(busy), 0);
    @(negedge clock);
    reset_n = 1'b1;
    query("t8_empty", 9, 9, 0, 0, 4, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/triangle_scan_ctrl.md
# triangle_scan_ctrl

- Sequencer that tests one query point against a bank of up to 2**TRI_AW stored triangles.
- Time-shares a single edge-function evaluator (one signed cross-product per cycle) across the three edges of each triangle and across triangle slots.
- Returns the lowest-index hit, or a miss, on a valid/ready result port.
- Sits between the point source and downstream hit consumers; replaces the free-running vertex-cycling counter with a configurable, handshaked scheduler.

## Interface
- TRI_AW, default 2: triangle slot address width; NTRI = 2**TRI_AW slots (1..16 supported).
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- cfg_we  in  1  vertex write strobe; honored only in IDLE
- cfg_addr  in  TRI_AW  triangle slot
- cfg_vtx  in  2  vertex select 0..2 (3 ignored)
- cfg_x, cfg_y  in  11  vertex coordinates, signed two's complement
- in_valid  in  1  query point offered
- in_ready  out  1  high in IDLE only
- in_x, in_y  in  11  query point, signed
- out_valid  out  1  result held until accepted
- out_ready  in  1  consumer accepts result
- out_hit  out  1  1 = point inside some valid triangle
- out_idx  out  TRI_AW  lowest hit slot; 0 on miss
- busy  out  1  high in EVAL or DONE

## Operation
- Storage: per slot, three (x,y) vertices plus a tri_valid bit.
  - Writing cfg_vtx=0 clears tri_valid; writing cfg_vtx=2 sets it.
  - cfg_we outside IDLE is dropped, with no storage change.
- Edge function for point p and edge (a,b):
  - s = (px-bx)*(ay-by) - (ax-bx)*(py-by)
  - Differences sign-extended to 12 bits, products 24 bits, s 25 bits signed. No truncation.
- Edges in order: E0=(v0,v1), E1=(v1,v2), E2=(v2,v0). Edge sign = s[24]; s==0 counts as non-negative.
- Hit rule: all three edge signs equal (all negative or all non-negative).
- States:
  - IDLE: in_ready=1. On in_valid, latch the point, set slot=0, edge=0, and go to EVAL.
  - EVAL, valid slot: evaluate one edge per cycle and register its sign. After E2, decide the slot.
  - EVAL, invalid slot: spend exactly 1 cycle and advance.
  - EVAL exit: on the first hit, go to DONE with out_hit=1 and out_idx=slot. After the last slot with no hit, go to DONE with out_hit=0 and out_idx=0.
  - DONE: out_valid=1, outputs stable. On out_ready, go to IDLE.
- No early reject: a valid slot always costs 3 cycles.

## Timing
- Reset values: in_ready=1, out_valid=0, out_hit=0, out_idx=0, busy=0.
- Reset also puts the FSM in IDLE, clears all tri_valid bits, and zeroes the vertex storage.
- Accept occurs at edge T0 (in_valid & in_ready). Edge evaluations start at T0+1.
- out_valid rises after edge T0+C, where C = 3 × (valid slots scanned, including the hit slot) + 1 × (invalid slots scanned).
- Full miss costs 3 × (valid slots) + (invalid slots) cycles. With all slots empty, C = NTRI.
- in_ready is 0 from T0+1 until the cycle after the out handshake. Back-to-back: next accept no earlier than the edge after out_valid & out_ready.
- out_ready held high before DONE has no effect. Result is held indefinitely while out_ready=0.
- Reset mid-EVAL or mid-DONE: result discarded, registers return to reset values immediately (asynchronous).
- Config write and in_valid in the same IDLE cycle: both are taken. The write lands at the same edge, so the scan sees the new vertex.

## Test plan
- Slot0 = (4,9),(9,5),(12,11); point (9,9) -> s = 20, 12, 10; out_hit=1, out_idx=0, out_valid after T0+3.
- Slot0 as above, slot1 = (6,1),(9,3),(-4,15); point (5,3) -> slot0 miss (-26, 18, ...), slot1 s = 8, 48, 6; out_hit=1, out_idx=1, out_valid after T0+6.
- Point (9,5), a vertex of slot0 -> s = 0, 0, 42; zero treated non-negative; out_hit=1, out_idx=0.
- Slots 0 and 1 loaded, slots 2 and 3 empty; point (3,1) -> miss, out_hit=0, out_idx=0, out_valid after T0+8. Then hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0.
- cfg_we to slot0 during EVAL -> ignored, slot0 unchanged. Rewrite slot0 vertex0 in IDLE -> tri_valid cleared; next query skips slot0 in 1 cycle.
- Deassert reset_n mid-EVAL -> out_valid=0 and in_ready=1 immediately; all slots invalid; next query misses after NTRI cycles.
